// File: rtl/logic_fold_unit.sv
// logic_fold_unit: folds a framed stream of WIDTH-bit operands through a
// selectable bitwise operator and presents one registered result per frame.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ena               design enable; low freezes every register
//   op                operator for the frame: 00 AND, 01 OR, 10 XOR, 11 NAND
//   in_valid/in_ready operand beat handshake
//   in_data, in_last  operand and end-of-frame marker
//   out_valid/out_ready result handshake
//   out_data          folded result (inverted for NAND)
//   out_count         number of beats folded into the result
//   busy              frame in progress or result waiting
module logic_fold_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   localparam logic [CNT_W-1:0] MaxBeats = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        op_q, op_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [CNT_W-1:0]  out_count_q, out_count_d;

   logic              accept;
   logic              pop;
   logic [1:0]        beat_op;
   logic [WIDTH-1:0]  beat_acc;
   logic [CNT_W-1:0]  beat_cnt;

   // NAND frames fold with AND; the inversion is applied once on the result.
   function automatic logic [WIDTH-1:0] fold(input logic [1:0]       f_op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (f_op)
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   always_comb begin
      in_ready    = rst_n && ena && ((state_q != StHold) || out_ready);
      accept      = in_valid && in_ready;
      pop         = ena && (state_q == StHold) && out_ready;

      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      op_d        = op_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      beat_op     = op_q;
      beat_acc    = acc_q;
      beat_cnt    = count_q;

      if (pop) begin
         state_d = StIdle;
      end

      if (accept) begin
         if (state_q == StAccum) begin
            beat_op  = op_q;
            beat_acc = fold(op_q, acc_q, in_data);
            beat_cnt = count_q + 1'b1;
         end else begin
            // First beat of a frame, either from idle or overlapping a result pop.
            beat_op     = op;
            beat_acc    = in_data;
            beat_cnt    = '0;
            beat_cnt[0] = 1'b1;
            op_d        = op;
         end
         acc_d   = beat_acc;
         count_d = beat_cnt;
         if (in_last || (beat_cnt == MaxBeats)) begin
            state_d     = StHold;
            out_data_d  = (beat_op == 2'b11) ? ~beat_acc : beat_acc;
            out_count_d = beat_cnt;
         end else begin
            state_d = StAccum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         count_q     <= '0;
         op_q        <= 2'b00;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         op_q        <= op_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = (state_q == StHold);
   assign busy      = (state_q != StIdle);
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_logic_fold_unit.sv
// Self-checking bench for logic_fold_unit: per-cycle vector table, hand-written
// corner sequences, and randomized traffic against a frame-level reference model.
module tb_logic_fold_unit;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [1:0] op;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_count;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic_fold_unit #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   typedef struct {
      logic [7:0] d;
      logic [3:0] c;
   } res_t;

   logic [7:0] frame_q[$];
   logic [1:0] frame_op;
   res_t       exp_q[$];

   function automatic logic [7:0] reference(input logic [1:0] f_op, input logic [7:0] b[$]);
      logic [7:0] r;
      r = b[0];
      for (int i = 1; i < b.size(); i++) begin
         if (f_op == 2'b01)      r = r | b[i];
         else if (f_op == 2'b10) r = r ^ b[i];
         else                    r = r & b[i];
      end
      if (f_op == 2'b11) r = ~r;
      return r;
   endfunction

   // Inputs change just after posedge, so negedge sees what the next edge will act on.
   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_ready;
         res_t r;
         exp_ready = ena && ((exp_q.size() == 0) || out_ready);
         check("m_out_valid", out_valid, exp_q.size() != 0);
         check("m_busy", busy, (frame_q.size() != 0) || (exp_q.size() != 0));
         check("m_in_ready", in_ready, exp_ready);
         if (exp_q.size() != 0) begin
            check("m_out_data", out_data, exp_q[0].d);
            check("m_out_count", out_count, exp_q[0].c);
            if (ena && out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && exp_ready) begin
            if (frame_q.size() == 0) frame_op = op;
            frame_q.push_back(in_data);
            if (in_last || (frame_q.size() == 15)) begin
               r.d = reference(frame_op, frame_q);
               r.c = 4'(frame_q.size());
               exp_q.push_back(r);
               frame_q.delete();
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] op;
      logic       v;
      logic [7:0] d;
      logic       last;
      logic       ordy;
      logic       ev;
      logic [7:0] ed;
      logic [3:0] ec;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] a_op, input logic a_v, input logic [7:0] a_d,
                      input logic a_last, input logic a_ordy, input logic a_ev,
                      input logic [7:0] a_ed, input logic [3:0] a_ec);
      vec_t t;
      t.op = a_op; t.v = a_v; t.d = a_d; t.last = a_last; t.ordy = a_ordy;
      t.ev = a_ev; t.ed = a_ed; t.ec = a_ec;
      tbl.push_back(t);
   endtask

   task automatic drive(input logic [1:0] d_op, input logic d_v, input logic [7:0] d_d,
                        input logic d_last, input logic d_ordy);
      op = d_op; in_valid = d_v; in_data = d_d; in_last = d_last; out_ready = d_ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1;
      drive(2'b00, 1'b1, 8'h00, 1'b0, 1'b1);

      // AND over three beats
      add(2'b00, 1, 8'hF0, 0, 1, 0, 8'h00, 4'd0);
      add(2'b00, 1, 8'h3C, 0, 1, 0, 8'h00, 4'd0);
      add(2'b00, 1, 8'hFF, 1, 1, 0, 8'h00, 4'd0);
      add(2'b00, 0, 8'h00, 0, 1, 1, 8'h30, 4'd3);
      add(2'b00, 0, 8'h00, 0, 1, 0, 8'h00, 4'd0);
      // XOR single beat, NAND two beats, back-to-back single-beat frames
      add(2'b10, 1, 8'hA5, 1, 1, 0, 8'h00, 4'd0);
      add(2'b11, 1, 8'hFF, 0, 1, 1, 8'hA5, 4'd1);
      add(2'b11, 1, 8'h0F, 1, 1, 0, 8'h00, 4'd0);
      add(2'b10, 1, 8'hA5, 1, 1, 1, 8'hF0, 4'd2);
      add(2'b00, 1, 8'h3C, 1, 1, 1, 8'hA5, 4'd1);
      add(2'b00, 0, 8'h00, 0, 1, 1, 8'h3C, 4'd1);
      add(2'b00, 0, 8'h00, 0, 1, 0, 8'h00, 4'd0);
      // op change mid-frame is ignored
      add(2'b00, 1, 8'hF0, 0, 1, 0, 8'h00, 4'd0);
      add(2'b01, 1, 8'h0F, 1, 1, 0, 8'h00, 4'd0);
      add(2'b01, 0, 8'h00, 0, 1, 1, 8'h00, 4'd2);
      add(2'b00, 0, 8'h00, 0, 1, 0, 8'h00, 4'd0);
      // backpressure for 5 cycles, then pop with a simultaneous new frame
      add(2'b00, 1, 8'hAA, 1, 0, 0, 8'h00, 4'd0);
      add(2'b00, 0, 8'h00, 0, 0, 1, 8'hAA, 4'd1);
      for (int i = 0; i < 4; i++) add(2'b00, 1, 8'h0F, 1, 0, 1, 8'hAA, 4'd1);
      add(2'b00, 1, 8'h0F, 1, 1, 1, 8'hAA, 4'd1);
      add(2'b00, 0, 8'h00, 0, 1, 1, 8'h0F, 4'd1);
      add(2'b00, 0, 8'h00, 0, 1, 0, 8'h00, 4'd0);

      // reset state
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_count", out_count, 4'h0);
      drive(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      step();
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].ordy);
         @(negedge clk);
         check($sformatf("t%0d_out_valid", i), out_valid, tbl[i].ev);
         check($sformatf("t%0d_in_ready", i), in_ready, !tbl[i].ev || tbl[i].ordy);
         if (tbl[i].ev) begin
            check($sformatf("t%0d_out_data", i), out_data, tbl[i].ed);
            check($sformatf("t%0d_out_count", i), out_count, tbl[i].ec);
         end
         step();
      end

      // forced close at 15 beats, 16th beat starts a new frame
      for (int i = 0; i < 15; i++) begin
         drive(2'b01, 1'b1, 8'(1 << (i % 8)), 1'b0, 1'b1);
         @(negedge clk);
         check("fc_no_valid", out_valid, 1'b0);
         step();
      end
      drive(2'b01, 1'b1, 8'h55, 1'b1, 1'b1);
      @(negedge clk);
      check("fc_valid", out_valid, 1'b1);
      check("fc_data", out_data, 8'hFF);
      check("fc_count", out_count, 4'd15);
      step();
      drive(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check("fc_next_data", out_data, 8'h55);
      check("fc_next_count", out_count, 4'd1);
      step();
      step();

      // asynchronous reset mid-frame, between edges
      drive(2'b00, 1'b1, 8'h12, 1'b0, 1'b1);
      step();
      drive(2'b00, 1'b1, 8'h34, 1'b0, 1'b1);
      step();
      check("pre_rst_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      frame_q.delete();
      exp_q.delete();
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_out_data", out_data, 8'h00);
      check("arst_in_ready", in_ready, 1'b0);
      drive(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      step();
      rst_n = 1'b1;
      step();

      // ena gap of 3 cycles mid-frame
      drive(2'b10, 1'b1, 8'h12, 1'b0, 1'b1);
      step();
      ena = 1'b0;
      drive(2'b10, 1'b1, 8'h34, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ena_in_ready", in_ready, 1'b0);
         check("ena_busy", busy, 1'b1);
         step();
      end
      ena = 1'b1;
      step();
      drive(2'b10, 1'b1, 8'h56, 1'b1, 1'b1);
      step();
      drive(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check("ena_valid", out_valid, 1'b1);
      check("ena_data", out_data, 8'h70);
      check("ena_count", out_count, 4'd3);
      step();

      // randomized traffic checked by the reference model
      for (int i = 0; i < 600; i++) begin
         ena = ($urandom % 8) != 0;
         drive(2'($urandom), 1'($urandom), 8'($urandom), ($urandom % 4) == 0, 1'($urandom));
         step();
      end
      ena = 1'b1;
      drive(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
